// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types and constants for the cluster power sequencer.
//   state_t   : 3-bit sequencer state. The values are visible on state_o.
//   ctrl_t    : bundle of the six registered cluster control lines.
//   ctrl_for  : the control-line values that apply while in a given state.
package cluster_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_CLK_RST = 3'd2,
    ST_ON      = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_HALT    = 3'd5,
    ST_CLK_OFF = 3'd6
  } state_t;

  typedef struct packed {
    logic pow;
    logic byp;
    logic clk_en;
    logic rstn;
    logic isolate;
    logic fetch;
  } ctrl_t;

  localparam int unsigned DEF_PWR_UP_CYCLES = 16;
  localparam int unsigned DEF_RST_CYCLES    = 8;
  localparam int unsigned DEF_IDLE_CYCLES   = 4;
  localparam int unsigned DEF_DRAIN_TIMEOUT = 1024;
  localparam int unsigned DEF_CNT_WIDTH     = 16;

  // Field order: pow, byp, clk_en, rstn, isolate, fetch.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    case (s)
      ST_PWR_UP:  c = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      ST_CLK_RST: c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ST_ON:      c = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      ST_DRAIN:   c = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      ST_HALT:    c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ST_CLK_OFF: c = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      default:    c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer. Walks the cluster domain through supply-on,
// clock/reset, run, drain and shutdown on one on/off request at a time.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake (ready only in OFF and ON)
//   req_on_i                1 = power up, 0 = power down
//   req_boot_addr_i         boot address, captured on an accepted power-up
//   done_o                  one-cycle completion pulse
//   timeout_o               sticky flag: last drain ended by timeout
//   state_o                 current state
//   cluster_busy_i          cluster activity, only looked at while draining
//   cluster_*_o             registered cluster controls and boot address
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int unsigned PWR_UP_CYCLES = DEF_PWR_UP_CYCLES,
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned IDLE_CYCLES   = DEF_IDLE_CYCLES,
  parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_on_i,
  input  logic [63:0] req_boot_addr_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [2:0]  state_o,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_byp_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_isolate_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o
);

  localparam logic [CNT_WIDTH-1:0] PU_LOAD   = CNT_WIDTH'(PWR_UP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LOAD  = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(DRAIN_TIMEOUT - 1);

  state_t               state;
  ctrl_t                ctrl;
  logic [CNT_WIDTH-1:0] cnt;       // phase down-counter, or total drain cycles
  logic [CNT_WIDTH-1:0] idle_cnt;  // consecutive idle cycles while draining
  logic                 ready;
  logic                 done;
  logic                 timeout;
  logic [63:0]          boot_addr;
  logic                 accept;

  assign accept = req_valid_i & ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_OFF;
      ctrl      <= ctrl_for(ST_OFF);
      cnt       <= '0;
      idle_cnt  <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
      boot_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_OFF: begin
          if (accept) begin
            timeout <= 1'b0;
            if (req_on_i) begin
              boot_addr <= req_boot_addr_i;
              state     <= ST_PWR_UP;
              ctrl      <= ctrl_for(ST_PWR_UP);
              ready     <= 1'b0;
              cnt       <= PU_LOAD;
            end else begin
              done <= 1'b1;  // already off
            end
          end
        end
        ST_PWR_UP: begin
          if (cnt == '0) begin
            state <= ST_CLK_RST;
            ctrl  <= ctrl_for(ST_CLK_RST);
            cnt   <= RST_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CLK_RST: begin
          if (cnt == '0) begin
            state <= ST_ON;
            ctrl  <= ctrl_for(ST_ON);
            ready <= 1'b1;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ON: begin
          if (accept) begin
            timeout <= 1'b0;
            if (!req_on_i) begin
              state    <= ST_DRAIN;
              ctrl     <= ctrl_for(ST_DRAIN);
              ready    <= 1'b0;
              cnt      <= '0;
              idle_cnt <= '0;
            end else begin
              done <= 1'b1;  // already on
            end
          end
        end
        ST_DRAIN: begin
          // The timeout check comes first so it wins over a same-cycle idle exit.
          if (cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= ST_HALT;
            ctrl    <= ctrl_for(ST_HALT);
          end else if (!cluster_busy_i && idle_cnt == IDLE_LAST) begin
            state <= ST_HALT;
            ctrl  <= ctrl_for(ST_HALT);
          end else begin
            // Both counters stay below their exit values here, so they cannot wrap.
            cnt      <= cnt + 1'b1;
            idle_cnt <= cluster_busy_i ? '0 : idle_cnt + 1'b1;
          end
        end
        ST_HALT: begin
          state <= ST_CLK_OFF;
          ctrl  <= ctrl_for(ST_CLK_OFF);
        end
        ST_CLK_OFF: begin
          state <= ST_OFF;
          ctrl  <= ctrl_for(ST_OFF);
          ready <= 1'b1;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_OFF;
          ctrl  <= ctrl_for(ST_OFF);
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o            = ready;
  assign done_o                 = done;
  assign timeout_o              = timeout;
  assign state_o                = state;
  assign cluster_pow_o          = ctrl.pow;
  assign cluster_byp_o          = ctrl.byp;
  assign cluster_clk_en_o       = ctrl.clk_en;
  assign cluster_rstn_o         = ctrl.rstn;
  assign cluster_isolate_o      = ctrl.isolate;
  assign cluster_fetch_enable_o = ctrl.fetch;
  assign cluster_boot_addr_o    = boot_addr;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Bench for cluster_pwr_seq: directed sequence plus randomized traffic,
// compared every cycle against a phase/age reference model.
module tb_cluster_pwr_seq;

  localparam int PU   = 16;
  localparam int RSTC = 8;
  localparam int IDLE = 4;
  localparam int TO   = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_on = 1'b0;
  logic [63:0] req_boot = '0;
  logic        done;
  logic        timeout;
  logic [2:0]  state;
  logic        busy = 1'b0;
  logic        pow, byp, clk_en, rstn, iso, fetch;
  logic [63:0] boot_out;

  always #5 clk = ~clk;

  cluster_pwr_seq #(
    .PWR_UP_CYCLES(PU), .RST_CYCLES(RSTC), .IDLE_CYCLES(IDLE),
    .DRAIN_TIMEOUT(TO), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_on_i(req_on),
    .req_boot_addr_i(req_boot), .done_o(done), .timeout_o(timeout),
    .state_o(state), .cluster_busy_i(busy),
    .cluster_pow_o(pow), .cluster_byp_o(byp), .cluster_clk_en_o(clk_en),
    .cluster_rstn_o(rstn), .cluster_isolate_o(iso),
    .cluster_fetch_enable_o(fetch), .cluster_boot_addr_o(boot_out)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: a coarse phase plus the number of cycles spent in it.
  localparam int PH_OFF = 0, PH_UP = 1, PH_ON = 2, PH_DRAIN = 3, PH_DOWN = 4;
  int          ph;
  int          age;
  int          drain_total;
  int          idle_run;
  bit          m_done;
  bit          m_tmo;
  logic [63:0] m_boot;

  function automatic int exp_state();
    case (ph)
      PH_UP:    return (age <= PU) ? 1 : 2;
      PH_ON:    return 3;
      PH_DRAIN: return 4;
      PH_DOWN:  return (age == 1) ? 5 : 6;
      default:  return 0;
    endcase
  endfunction

  // {pow, byp, clk_en, rstn, isolate, fetch} for each visible state value.
  function automatic logic [5:0] ctrl_of(input int st);
    case (st)
      1:       return 6'b110010;
      2:       return 6'b101010;
      3:       return 6'b101101;
      4:       return 6'b101100;
      5:       return 6'b101010;
      6:       return 6'b110010;
      default: return 6'b010010;
    endcase
  endfunction

  task automatic model_reset();
    ph = PH_OFF; age = 0; drain_total = 0; idle_run = 0;
    m_done = 1'b0; m_tmo = 1'b0; m_boot = '0;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    case (ph)
      PH_OFF: if (req_valid) begin
        m_tmo = 1'b0;
        if (req_on) begin m_boot = req_boot; ph = PH_UP; age = 1; end
        else m_done = 1'b1;
      end
      PH_UP: begin
        age++;
        if (age == PU + RSTC + 1) begin ph = PH_ON; m_done = 1'b1; end
      end
      PH_ON: if (req_valid) begin
        m_tmo = 1'b0;
        if (!req_on) begin ph = PH_DRAIN; drain_total = 0; idle_run = 0; end
        else m_done = 1'b1;
      end
      PH_DRAIN: begin
        drain_total++;
        idle_run = busy ? 0 : idle_run + 1;
        if (drain_total == TO) begin m_tmo = 1'b1; ph = PH_DOWN; age = 1; end
        else if (idle_run == IDLE) begin ph = PH_DOWN; age = 1; end
      end
      default: begin
        age++;
        if (age == 3) begin ph = PH_OFF; m_done = 1'b1; end
      end
    endcase
  endtask

  task automatic check(input string tag);
    logic [11:0] obs, exp;
    logic [2:0]  s3;
    int          st;
    st  = exp_state();
    s3  = 3'(st);
    obs = {state, pow, byp, clk_en, rstn, iso, fetch, req_ready, done, timeout};
    exp = {s3, ctrl_of(st), (st == 0 || st == 3), m_done, m_tmo};
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s ctrl observed=%h expected=%h (state,pow,byp,clk_en,rstn,iso,fetch,ready,done,tmo)", tag, obs, exp);
    end
    checks++;
    assert (boot_out === m_boot) else begin
      fails++;
      $error("FAIL %s boot_addr observed=%h expected=%h", tag, boot_out, m_boot);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    check(tag);
  endtask

  task automatic step(input bit v, input bit on, input logic [63:0] a, input bit b,
                      input string tag);
    req_valid = v; req_on = on; req_boot = a; busy = b;
    tick(tag);
  endtask

  // Random requests only while the sequencer is in transit (they must be held
  // off); busy_mode 0 = low, 1 = high, 2 = random.
  task automatic run(input int n, input int busy_mode, input string tag);
    for (int i = 0; i < n; i++) begin
      req_valid = (ph == PH_OFF || ph == PH_ON) ? 1'b0 : 1'($urandom_range(0, 1));
      req_on    = 1'($urandom_range(0, 1));
      req_boot  = {$urandom, $urandom};
      busy      = (busy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(busy_mode);
      tick(tag);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check(tag);
    req_valid = 1'b0;
    tick({tag, "_hold"});
    #1 rst = 1'b0;
  endtask

  bit busy_pat [0:5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    model_reset();
    tick("reset");
    tick("reset");
    rst = 1'b0;
    step(0, 0, '0, 0, "idle_off");

    // Power-up with a fixed boot address; stray requests while in transit.
    step(1, 1, 64'h0000_0000_1C00_8080, 0, "pu_req");
    run(30, 2, "pu_seq");
    step(1, 1, {$urandom, $urandom}, 0, "redundant_on");
    step(0, 0, '0, 0, "after_redundant");

    // Power-down with an idle cluster.
    step(1, 0, '0, 0, "pd_req");
    run(10, 0, "pd_idle");
    step(1, 0, '0, 1, "redundant_off");

    // Busy toggling during drain.
    step(1, 1, {$urandom, $urandom}, 0, "pu_req2");
    run(28, 2, "pu_seq2");
    step(1, 0, '0, 1, "pd_req2");
    for (int i = 0; i < 6; i++) step(0, 0, '0, busy_pat[i], "drain_toggle");
    run(12, 0, "drain_toggle_tail");

    // Drain timeout with busy stuck high; flag stays until the next accept.
    step(1, 1, {$urandom, $urandom}, 0, "pu_req3");
    run(28, 2, "pu_seq3");
    step(1, 0, '0, 1, "pd_req3");
    run(TO + 6, 1, "drain_timeout");
    run(5, 1, "timeout_sticky");
    step(1, 1, {$urandom, $urandom}, 0, "timeout_clear");
    run(5, 2, "pu_seq4");

    // Reset in the tenth PWR_UP cycle.
    run(30, 2, "settle");
    step(1, 0, '0, 0, "pd_req4");
    run(10, 0, "pd_idle2");
    step(1, 1, {$urandom, $urandom}, 0, "pu_req5");
    run(9, 2, "pu_pre_rst");
    async_reset("rst_mid_pwr_up");

    // Reset in the middle of a drain.
    step(1, 1, {$urandom, $urandom}, 0, "pu_req6");
    run(26, 2, "pu_seq6");
    step(1, 0, '0, 1, "pd_req6");
    run(20, 1, "drain_busy");
    async_reset("rst_mid_drain");

    // Unconstrained random traffic.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_on    = 1'($urandom_range(0, 1));
      req_boot  = {$urandom, $urandom};
      busy      = 1'($urandom_range(0, 1));
      tick("random");
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
